// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between fetch (req[0]), read (req[1]) and write (req[2]) with a fetch starvation guard.
// Optional BUSY timeout with error response: define MEM_BUS_ARBITER_TIMEOUT_EN.
module mem_bus_arbiter #(
  parameter int WIDTH          = 32,
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [2:0]         req,
  input  logic [3*WIDTH-1:0] req_address,
  input  logic [2:0]         req_write,
  input  logic [3*WIDTH-1:0] req_write_data,
  output logic [2:0]         rsp_valid,
  output logic [WIDTH-1:0]   rsp_data,
  output logic [2:0]         rsp_error,
  output logic               mem_address_enable,
  output logic [WIDTH-1:0]   mem_address,
  output logic               mem_write_enable,
  output logic [WIDTH-1:0]   mem_write_data,
  input  logic               mem_data_valid,
  input  logic [WIDTH-1:0]   mem_data
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q, state_d;
  logic [1:0]       owner_q, owner_d;
  logic [SW-1:0]    starve_q, starve_d;
  logic             mae_q, mae_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic             we_q, we_d;
  logic [WIDTH-1:0] wd_q, wd_d;
  logic [2:0]       rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [1:0]       win;
  logic [WIDTH-1:0] addr_arr [4];
  logic [WIDTH-1:0] wd_arr [4];

`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYCLES);
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    rsp_error_q, rsp_error_d;
`endif

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      addr_arr[i] = req_address[i*WIDTH +: WIDTH];
      wd_arr[i]   = req_write_data[i*WIDTH +: WIDTH];
    end
    addr_arr[3] = '0;
    wd_arr[3]   = '0;
    // A fetch that has lost STARVE_LIMIT arbitrations in a row overrides priority.
    if (req[0] && (starve_q >= STARVE_MAX)) win = 2'd0;
    else if (req[2])                        win = 2'd2;
    else if (req[1])                        win = 2'd1;
    else                                    win = 2'd0;
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    starve_d    = starve_q;
    mae_d       = 1'b0;
    addr_d      = addr_q;
    we_d        = we_q;
    wd_d        = wd_q;
    rsp_valid_d = 3'b000;
    rsp_data_d  = rsp_data_q;
`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
    timer_d     = timer_q;
    rsp_error_d = 3'b000;
`endif
    case (state_q)
      IDLE: begin
        if (|req) begin
          owner_d = win;
          mae_d   = 1'b1;
          addr_d  = addr_arr[win];
          we_d    = req_write[win] && (win != 2'd0);
          wd_d    = wd_arr[win];
          state_d = BUSY;
          if (win == 2'd0)                          starve_d = '0;
          else if (req[0] && (starve_q < STARVE_MAX)) starve_d = starve_q + 1'b1;
`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
          timer_d = '0;
`endif
        end
      end
      BUSY: begin
        if (mem_data_valid) begin
          rsp_valid_d = 3'b001 << owner_q;
          rsp_data_d  = mem_data;
          state_d     = IDLE;
`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
        end else if (timer_q == TIMER_MAX) begin
          rsp_error_d = 3'b001 << owner_q;
          state_d     = IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= 2'd0;
      starve_q    <= '0;
      mae_q       <= 1'b0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wd_q        <= '0;
      rsp_valid_q <= 3'b000;
      rsp_data_q  <= '0;
`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
      timer_q     <= '0;
      rsp_error_q <= 3'b000;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      starve_q    <= starve_d;
      mae_q       <= mae_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wd_q        <= wd_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
      timer_q     <= timer_d;
      rsp_error_q <= rsp_error_d;
`endif
    end
  end

  assign mem_address_enable = mae_q;
  assign mem_address        = addr_q;
  assign mem_write_enable   = we_q;
  assign mem_write_data     = wd_q;
  assign rsp_valid          = rsp_valid_q;
  assign rsp_data           = rsp_data_q;
`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
  assign rsp_error          = rsp_error_q;
`else
  assign rsp_error          = 3'b000;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: requester queues and a memory responder around a transaction-level reference model.
// Inputs change on the falling edge; outputs are sampled on the falling edge before new inputs are applied.
module tb_mem_bus_arbiter;
  localparam int W  = 32;
  localparam int SL = 4;
`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 64;
`endif

  logic           clock = 1'b0;
  logic           reset;
  logic [2:0]     req;
  logic [3*W-1:0] req_address;
  logic [2:0]     req_write;
  logic [3*W-1:0] req_write_data;
  logic [2:0]     rsp_valid;
  logic [W-1:0]   rsp_data;
  logic [2:0]     rsp_error;
  logic           mem_address_enable;
  logic [W-1:0]   mem_address;
  logic           mem_write_enable;
  logic [W-1:0]   mem_write_data;
  logic           mem_data_valid;
  logic [W-1:0]   mem_data;

  mem_bus_arbiter #(.WIDTH(W), .STARVE_LIMIT(SL), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset), .req(req), .req_address(req_address),
    .req_write(req_write), .req_write_data(req_write_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_error(rsp_error),
    .mem_address_enable(mem_address_enable), .mem_address(mem_address),
    .mem_write_enable(mem_write_enable), .mem_write_data(mem_write_data),
    .mem_data_valid(mem_data_valid), .mem_data(mem_data)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  // ---------------- state ----------------
  typedef struct { logic [W-1:0] addr; logic wr; logic [W-1:0] data; } txn_t;
  typedef struct packed { logic [2:0] mask; logic [1:0] n; logic [5:0] order; } vec_t;

  txn_t         rq [3][$];
  logic [W+2:0] exp_q [$];  // {is_error, owner[1:0], data}
  logic [W-1:0] strobe_log [$];
  int           strobe_cyc_q [$];
  int           n_tests = 0, n_fail = 0, cyc = 0, err_cyc = -1;
  int           rsp_cnt [3];
  bit           exp_strobe, model_busy;
  int           model_owner, losses, age;
  logic [W-1:0] exp_addr, exp_wd, last_addr, last_wd, fixed_data;
  logic         exp_we, last_we;
  bit           mem_pending, mem_never, spurious_en, fixed_data_en, drop_fetch;
  int           mem_cnt, delay_fixed;
  vec_t         vecs [6];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] m, input logic [1:0] n,
                              input logic [1:0] o0, input logic [1:0] o1, input logic [1:0] o2);
    return {m, n, o2, o1, o0};
  endfunction

  function automatic logic [W-1:0] addr_of(input int i);
    return (i == 0) ? 32'h100 : (i == 1) ? 32'h80 : 32'h40;
  endfunction

  function automatic int owner_of(input logic [W-1:0] a);
    return a[8] ? 0 : a[7] ? 1 : a[6] ? 2 : 3;
  endfunction

  task automatic push(input int r, input logic [W-1:0] a, input logic wr, input logic [W-1:0] d);
    txn_t t;
    t.addr = a; t.wr = wr; t.data = d;
    rq[r].push_back(t);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin rq[i].delete(); rsp_cnt[i] = 0; end
    exp_q.delete(); strobe_log.delete(); strobe_cyc_q.delete();
    exp_strobe = 0; model_busy = 0; model_owner = 0; losses = 0; age = 0;
    last_addr = '0; last_we = 1'b0; last_wd = '0;
    mem_pending = 0; mem_never = 0; spurious_en = 0; fixed_data_en = 0;
    drop_fetch = 0; delay_fixed = 0; err_cyc = -1;
    req = 3'b000; mem_data_valid = 1'b0; mem_data = '0;
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {rsp_valid, rsp_data, rsp_error, mem_address_enable, mem_address,
               mem_write_enable, mem_write_data}, '0);
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    model_reset();
    repeat (2) @(negedge clock);
    chk_all_zero("reset_state");
    reset = 1'b0;
  endtask

  // ---------------- driver + model, one clock per call ----------------
  task automatic step();
    logic [W+2:0] e;
    logic [2:0]   ev;
    int           w;
    @(negedge clock);
    cyc++;
    if (exp_strobe) begin
      chk("strobe", mem_address_enable, 1'b1);
      chk("strobe_address", mem_address, exp_addr);
      chk("strobe_write_enable", mem_write_enable, exp_we);
      chk("strobe_write_data", mem_write_data, exp_wd);
      last_addr = exp_addr; last_we = exp_we; last_wd = exp_wd;
    end else begin
      chk("no_strobe", mem_address_enable, 1'b0);
      chk("mem_hold", {mem_address, mem_write_enable, mem_write_data}, {last_addr, last_we, last_wd});
    end
    if (mem_address_enable) begin
      strobe_log.push_back(mem_address);
      strobe_cyc_q.push_back(cyc);
    end
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      ev = 3'b001 << e[W+1:W];
      if (e[W+2]) begin
        chk("rsp_error", {rsp_valid, rsp_error}, {3'b000, ev});
      end else begin
        chk("rsp_valid", {rsp_valid, rsp_error}, {ev, 3'b000});
        chk("rsp_data", rsp_data, e[W-1:0]);
      end
    end else begin
      chk("no_rsp", {rsp_valid, rsp_error}, 6'b0);
    end
    if (rsp_error != 3'b000 && err_cyc < 0) err_cyc = cyc;
    // requesters retire their head on a completion or an error
    for (int i = 0; i < 3; i++) begin
      if (rsp_valid[i]) rsp_cnt[i]++;
      if ((rsp_valid[i] || rsp_error[i]) && rq[i].size() > 0) void'(rq[i].pop_front());
    end
    if (drop_fetch && model_busy && model_owner == 0) begin
      rq[0].delete();
      drop_fetch = 0;
    end
    // memory responder
    mem_data_valid = 1'b0;
    mem_data = $urandom;
    if (mem_address_enable && !mem_never) begin
      mem_pending = 1;
      mem_cnt = (delay_fixed > 0) ? delay_fixed : $urandom_range(1, 4);
    end
    if (mem_pending) begin
      if (mem_cnt == 0) begin
        mem_data_valid = 1'b1;
        if (fixed_data_en) mem_data = fixed_data;
        mem_pending = 0;
      end else begin
        mem_cnt--;
      end
    end else if (spurious_en && !model_busy && $urandom_range(0, 3) == 0) begin
      mem_data_valid = 1'b1;
    end
    for (int i = 0; i < 3; i++) begin
      req[i] = (rq[i].size() > 0);
      if (rq[i].size() > 0) begin
        req_address[i*W +: W]    = rq[i][0].addr;
        req_write[i]             = rq[i][0].wr;
        req_write_data[i*W +: W] = rq[i][0].data;
      end
    end
    // reference model for the cycle just driven
    exp_strobe = 0;
    if (!model_busy) begin
      if (req != 3'b000) begin
        if (req[0] && losses >= SL) w = 0;
        else if (req[2])            w = 2;
        else if (req[1])            w = 1;
        else                        w = 0;
        if (w == 0)      losses = 0;
        else if (req[0]) losses = (losses + 1 > SL) ? SL : losses + 1;
        exp_addr = rq[w][0].addr;
        exp_we   = (w == 0) ? 1'b0 : rq[w][0].wr;
        exp_wd   = rq[w][0].data;
        exp_strobe = 1; model_busy = 1; model_owner = w; age = 0;
      end
    end else if (mem_data_valid) begin
      exp_q.push_back({1'b0, 2'(model_owner), mem_data});
      model_busy = 0;
`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
    end else if (age == TO) begin
      exp_q.push_back({1'b1, 2'(model_owner), {W{1'b0}}});
      model_busy = 0;
    end else begin
      age++;
`endif
    end
  endtask

  task automatic run_until_idle(input int bound);
    int n = 0;
    while ((rq[0].size() + rq[1].size() + rq[2].size() + exp_q.size() > 0 ||
            model_busy || exp_strobe || mem_pending) && n < bound) begin
      step();
      n++;
    end
    chk("drain_within_bound", n < bound, 1'b1);
    repeat (3) step();
  endtask

  // ---------------- tests ----------------
  initial begin
    int r;
    vec_t v;
    reset = 1'b1;
    req = '0; req_address = '0; req_write = '0; req_write_data = '0;
    mem_data_valid = 1'b0; mem_data = '0;

    vecs[0] = mk(3'b001, 2'd1, 2'd0, 2'd0, 2'd0);
    vecs[1] = mk(3'b111, 2'd3, 2'd2, 2'd1, 2'd0);
    vecs[2] = mk(3'b110, 2'd2, 2'd2, 2'd1, 2'd0);
    vecs[3] = mk(3'b011, 2'd2, 2'd1, 2'd0, 2'd0);
    vecs[4] = mk(3'b101, 2'd2, 2'd2, 2'd0, 2'd0);
    vecs[5] = mk(3'b010, 2'd1, 2'd1, 2'd0, 2'd0);

    // single fetch, memory answers 2 cycles after the strobe
    reset_dut();
    delay_fixed = 2; fixed_data_en = 1; fixed_data = 32'hDEADBEEF;
    push(0, 32'h100, 1'b0, 32'h0);
    run_until_idle(20);
    chk("single_fetch_strobes", strobe_log.size(), 1);
    chk("single_fetch_rsp_count", rsp_cnt[0], 1);

    // table: simultaneous requests served in priority order
    for (int k = 0; k < 6; k++) begin
      v = vecs[k];
      reset_dut();
      for (int i = 0; i < 3; i++)
        if (v.mask[i]) push(i, addr_of(i), (i != 1), (i == 2) ? 32'h55 : 32'h11 * (i + 1));
      run_until_idle(40);
      chk("vec_strobe_count", strobe_log.size(), v.n);
      for (int j = 0; j < int'(v.n) && j < strobe_log.size(); j++)
        chk("vec_order", owner_of(strobe_log[j]), v.order[j*2 +: 2]);
    end

    // fetch starvation against a read that re-requests every time
    reset_dut();
    for (int k = 0; k < 6; k++) push(1, 32'h80 + 4 * k, 1'b0, 32'h0);
    push(0, 32'h100, 1'b0, 32'h0);
    push(0, 32'h104, 1'b0, 32'h0);
    run_until_idle(100);
    chk("starve_strobe_count", strobe_log.size(), 8);
    for (int j = 0; j < 8 && j < strobe_log.size(); j++)
      chk("starve_order", owner_of(strobe_log[j]), (j == 4 || j == 7) ? 0 : 1);

    // asynchronous reset while BUSY, then a late memory response
    reset_dut();
    delay_fixed = 4;
    push(1, 32'h80, 1'b0, 32'h0);
    step();
    step();
    chk("busy_strobe_seen", strobe_log.size(), 1);
    #2 reset = 1'b1;
    #1 chk_all_zero("async_reset_outputs");
    model_reset();
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    mem_pending = 1; mem_cnt = 1;
    repeat (4) step();
    chk("late_rsp_ignored", rsp_cnt[0] + rsp_cnt[1] + rsp_cnt[2], 0);
    push(1, 32'h84, 1'b0, 32'h0);
    run_until_idle(20);
    chk("post_reset_read_count", rsp_cnt[1], 1);

    // fetch drops its request while its transaction is in flight
    reset_dut();
    delay_fixed = 3;
    push(0, 32'h100, 1'b0, 32'h0);
    push(0, 32'h104, 1'b0, 32'h0);
    drop_fetch = 1;
    run_until_idle(30);
    chk("drop_strobes", strobe_log.size(), 1);
    chk("drop_rsp_count", rsp_cnt[0], 1);

`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
    // memory never answers: read times out, queued fetch follows
    reset_dut();
    mem_never = 1;
    push(1, 32'h80, 1'b0, 32'h0);
    push(0, 32'h100, 1'b0, 32'h0);
    run_until_idle(100);
    chk("timeout_strobes", strobe_cyc_q.size(), 2);
    if (strobe_cyc_q.size() == 2) begin
      chk("timeout_error_delay", err_cyc - strobe_cyc_q[0], 9);
      chk("timeout_next_strobe", strobe_cyc_q[1] - err_cyc, 1);
    end
`endif

    // randomized traffic with spurious idle responses
    reset_dut();
    spurious_en = 1;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 2) == 0) begin
        r = $urandom_range(0, 2);
        if (rq[r].size() < 3) push(r, $urandom, 1'($urandom_range(0, 1)), $urandom);
      end
      step();
    end
    spurious_en = 0;
    run_until_idle(200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single memory bus between the fetch, read and write pipeline stages.
- Fixed priority: write > read > fetch. A starvation guard makes sure fetch still makes progress.
- Accepts one outstanding transaction at a time and routes the memory response back to the requester that owns it.
- Sits between the stage modules and the external memory port.

Parameters:
- WIDTH, 32, address/data width in bits.
- STARVE_LIMIT, 4, consecutive lost arbitrations after which a pending fetch request wins.
- TIMEOUT_CYCLES, 64, BUSY cycles without a memory response before abort (optional feature only).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  3  request per requester: bit0 fetch, bit1 read, bit2 write.
- req_address  in  3*WIDTH  per-requester address; slice i = [i*WIDTH +: WIDTH].
- req_write  in  3  per-requester write flag. Fetch bit is ignored and treated as 0.
- req_write_data  in  3*WIDTH  per-requester store data.
- rsp_valid  out  3  one-cycle completion pulse to the owning requester.
- rsp_data  out  WIDTH  response data; meaningful while any rsp_valid bit is set.
- rsp_error  out  3  one-cycle timeout pulse to the owner. Constant 0 without the optional feature.
- mem_address_enable  out  1  one-cycle request strobe to memory.
- mem_address  out  WIDTH  memory address.
- mem_write_enable  out  1  qualifies the strobe as a store.
- mem_write_data  out  WIDTH  store data.
- mem_data_valid  in  1  memory completion (load data valid, or store acknowledged).
- mem_data  in  WIDTH  load data.

Behaviour:
- Reset (asynchronous, any time, including mid-transaction):
  - State returns to IDLE; owner = 0; starve_count = 0.
  - All outputs are 0.
  - An in-flight memory response arriving after reset is ignored.
- States: IDLE, BUSY. All outputs are registered.
- IDLE, when some req bit is set in cycle N:
  - Pick the winner:
    - if req[0] and starve_count >= STARVE_LIMIT, the winner is fetch;
    - otherwise the highest set bit of req wins.
  - Latch the winner's address, write flag and data onto the mem_* outputs.
  - Assert mem_address_enable for exactly cycle N+1; record owner; go to BUSY.
- IDLE with no request: mem_address_enable stays 0. mem_address, mem_write_enable and mem_write_data hold their last values.
- Starvation counter (updated only at an arbitration):
  - fetch wins -> starve_count clears to 0;
  - fetch requested but lost -> starve_count increments, saturating at STARVE_LIMIT;
  - fetch not requesting -> starve_count is unchanged.
- BUSY:
  - mem_address_enable is 0. The mem_* address/data outputs remain stable.
  - On a cycle with mem_data_valid = 1:
    - the next cycle pulses rsp_valid[owner] = 1 with rsp_data = mem_data (data is captured even for stores);
    - the state returns to IDLE.
  - Arbitration resumes in IDLE on the cycle after completion. Minimum spacing between strobes is 3 cycles (strobe, response, IDLE decision). Back-to-back strobes are never issued.
- mem_data_valid while IDLE is ignored.
- Requesters hold req and operands stable until their rsp_valid.
- Dropping req while BUSY (e.g., fetch flushing on a PC change):
  - the transaction still completes and rsp_valid is still pulsed;
  - the requester discards the response;
  - no new request is issued on the dropped requester's behalf.
- rsp_valid is at most one-hot; rsp_valid and rsp_error are never both set.
- Latency: request visible in cycle N -> strobe in N+1 -> response pulse one cycle after mem_data_valid.

Optional Feature:
- Macro: MEM_BUS_ARBITER_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on entry to BUSY and increments every BUSY cycle without mem_data_valid.
  - After TIMEOUT_CYCLES such cycles, the next cycle pulses rsp_error[owner] = 1 (rsp_valid stays 0) and returns to IDLE.
  - mem_data_valid on the same cycle the limit is reached takes precedence: normal completion, no error.
- Not defined: no counter; rsp_error tied to 0; BUSY waits indefinitely.

Test Plan:
- Single fetch, req=3'b001 at address 0x100; memory responds 2 cycles after the strobe with 0xDEADBEEF -> one-cycle strobe with mem_address=0x100 and mem_write_enable=0, then rsp_valid=3'b001 with rsp_data=0xDEADBEEF; no other strobe.
- Simultaneous req=3'b111, write to 0x40 with data 0x55 -> first strobe is the write (mem_write_enable=1, mem_write_data=0x55); then the read; then the fetch, with responses routed to rsp_valid bits 2, 1, 0 in that order.
- Fetch starvation: fetch held high while read re-requests immediately after every completion, STARVE_LIMIT=4 -> the 5th strobe belongs to fetch; the fetch win clears starve_count, and with read still contending, read wins the 6th arbitration.
- Reset asserted while BUSY, then released, then a late mem_data_valid -> all outputs 0 immediately on reset; the late response produces no rsp_valid; the next req=3'b010 arbitrates normally.
- Fetch drops req while BUSY, then mem_data_valid arrives -> rsp_valid[0] still pulses once; no further fetch strobe is issued.
- With MEM_BUS_ARBITER_TIMEOUT_EN, TIMEOUT_CYCLES=8, read request and memory never responds -> rsp_error=3'b010 pulses 9 cycles after the strobe, state returns to IDLE, and a queued fetch is strobed 1 cycle after that.
